serial_word_deserializer: RTL and testbench
===========================================

// Module: serial_word_deserializer
// PURPOSE
//   Assembles a 1-bit serial stream, qualified by a per-bit valid strobe, into WIDTH-bit words.
//   Directly upstream of priority_encoder: deser_data_o/deser_data_val_o drive its data_i/data_val_i.
//   A gap watchdog discards a partial word when the stream stalls mid-word and reports it on drop_o.
// PARAMETERS
//   WIDTH        16  word width in bits; >= 2
//   LSB_FIRST    0   0: first received bit lands in bit WIDTH-1; 1: first bit lands in bit 0
//   GAP_TIMEOUT  8   idle cycles tolerated mid-word before the partial word is dropped; 0 = watchdog off
// PORTS
//   clk_i             in   1      single clock, all logic on posedge
//   srst_i            in   1      synchronous reset, active-high
//   data_i            in   1      serial data bit, sampled only when data_val_i=1
//   data_val_i        in   1      bit qualifier; no backpressure, every qualified bit is consumed
//   deser_data_o      out  WIDTH  last completed word; holds its value until the next word completes
//   deser_data_val_o  out  1      one-cycle pulse, deser_data_o valid in the same cycle
//   drop_o            out  1      one-cycle pulse, partial word discarded by the watchdog
// BEHAVIOUR
//   - Reset: deser_data_o=0, deser_data_val_o=0, drop_o=0, bit count=0, idle count=0, shift reg=0.
//     srst_i wins over all other inputs. A partial word present at reset is lost; no drop_o pulse.
//   - Bit count width: $clog2(WIDTH+1). Idle count width: $clog2(GAP_TIMEOUT+1), saturating.
//   - Two states: IDLE (count=0) and COLLECT (0<count<WIDTH).
//     IDLE->COLLECT on the first qualified bit.
//     COLLECT->IDLE on the WIDTH-th bit or on a watchdog drop.
//   - Shift: LSB_FIRST=0 -> sr <= {sr[WIDTH-2:0],data_i}; LSB_FIRST=1 -> sr <= {data_i,sr[WIDTH-1:1]}.
//   - Completion: the WIDTH-th qualified bit is sampled at edge k.
//     At the same edge k, deser_data_o is loaded with the full word (shift reg plus this bit)
//     and deser_data_val_o goes high for exactly one cycle. Latency is 1 clock from the last bit.
//   - Back-to-back words: bit 0 of the next word may arrive in the cycle right after completion.
//     That bit is accepted with no lost bits. Continuous data_val_i gives one pulse every WIDTH cycles.
//   - Watchdog: in COLLECT, each cycle with data_val_i=0 increments the idle count.
//     Any qualified bit clears the idle count to 0.
//     When the idle count reaches GAP_TIMEOUT at edge k:
//       bit count and idle count clear; drop_o=1 for the one cycle following edge k;
//       deser_data_o is unchanged; deser_data_val_o stays 0.
//   - The idle count is held at 0 in IDLE. A drop and a completion cannot coincide:
//     a drop needs data_val_i=0, a completion needs data_val_i=1.
//   - GAP_TIMEOUT=0: the watchdog is removed and drop_o is tied to 0.
//     A partial word then waits indefinitely.
//   - data_i is ignored (don't-care) when data_val_i=0; X on data_i must not propagate.
// STRUCTURE
//   - Package serial_pkg holds the shared width constant DATA_WIDTH=16.
//     priority_encoder and this block both reference it.
//   - Sub-module gap_watchdog (params GAP_TIMEOUT):
//     inputs clk_i, srst_i, active_i, kick_i; output expire_o (one-cycle pulse).
//   - Top level holds the bit counter, shift register, output register and drop_o register.
// TESTING
//   1. LSB_FIRST=0: 16 consecutive bits of 16'hA5C3, MSB first.
//      -> deser_data_o=16'hA5C3 with a 1-cycle deser_data_val_o pulse, 1 clk after the 16th bit.
//   2. LSB_FIRST=1: same bit stream as test 1.
//      -> deser_data_o=16'hC3A5, same timing as test 1.
//   3. GAP_TIMEOUT=8: 16'h8001 with 3-cycle gaps inserted after bits 4 and 11.
//      -> word 16'h8001 completes; drop_o never asserts.
//   4. GAP_TIMEOUT=8: 5 bits, then 8 idle cycles, then 16 bits of 16'h00FF.
//      -> drop_o pulses once; deser_data_o=16'h00FF afterwards, with no residue from the 5 bits.
//   5. data_val_i high for 32 cycles carrying 16'h1234 then 16'hFFFF.
//      -> two deser_data_val_o pulses exactly 16 cycles apart, with the correct words.
//   6. srst_i asserted after 9 bits, then 16 bits of 16'h0F0F.
//      -> outputs at reset values, no drop_o; then deser_data_o=16'h0F0F.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants for the serial front end (deserializer and priority encoder).
// Holds the common data width and the deserializer's two state codes.
// No logic lives here.
package serial_pkg;

  localparam int DATA_WIDTH = 16;

  // Deserializer states: IDLE while no bits are held, COLLECT while a word is partial.
  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_COLLECT = 1'b1;

endpackage

// File: rtl/gap_watchdog.sv
// Idle-gap watchdog: counts stalled cycles while a partial word is held.
// expire_o is combinational and fires when this edge would bring the idle count to GAP_TIMEOUT.
// The caller registers it into its own drop pulse. GAP_TIMEOUT=0 removes the counter entirely.
module gap_watchdog #(
  parameter int GAP_TIMEOUT = 8
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic active_i,
  input  logic kick_i,
  output logic expire_o
);

  if (GAP_TIMEOUT > 0) begin : g_wd
    localparam int ICW = $clog2(GAP_TIMEOUT + 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(GAP_TIMEOUT - 1);
    localparam logic [ICW-1:0] IDLE_MAX  = ICW'(GAP_TIMEOUT);

    logic [ICW-1:0] idle_q;
    logic [ICW-1:0] idle_d;
    logic           expire;

    // Next idle count: held at zero outside COLLECT or on any qualified bit, saturating otherwise.
    always_comb begin
      expire = active_i && !kick_i && (idle_q == IDLE_LAST);
      idle_d = idle_q;
      if (!active_i || kick_i || expire) begin
        idle_d = '0;
      end else if (idle_q != IDLE_MAX) begin
        idle_d = idle_q + 1'b1;
      end
    end

    // Idle counter register.
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_d;
      end
    end

    assign expire_o = expire;
  end else begin : g_off
    logic unused_wd;
    assign unused_wd = ^{clk_i, srst_i, active_i, kick_i};
    assign expire_o  = 1'b0;
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel word assembler with a mid-word gap watchdog.
// A word appears on deser_data_o one clock after its last bit, with a one-cycle valid pulse.
// There is no backpressure: every qualified bit is consumed, and back-to-back words lose no bits.
module serial_word_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH       = DATA_WIDTH,
  parameter int LSB_FIRST   = 0,
  parameter int GAP_TIMEOUT = 8
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             data_i,
  input  logic             data_val_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic             deser_data_val_o,
  output logic             drop_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             val_q, val_d;
  logic             drop_q, drop_d;
  logic [WIDTH-1:0] sr_shift;
  logic             state;
  logic             expire;

  // State is implied by the bit count: any held bit means a word is in progress.
  assign state = (cnt_q != '0) ? ST_COLLECT : ST_IDLE;

  // Shift register contents once the current data_i is included.
  if (LSB_FIRST != 0) begin : g_lsb
    assign sr_shift = {data_i, sr_q[WIDTH-1:1]};
  end else begin : g_msb
    assign sr_shift = {sr_q[WIDTH-2:0], data_i};
  end

  gap_watchdog #(
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_gap_watchdog (
    .clk_i    (clk_i),
    .srst_i   (srst_i),
    .active_i (state == ST_COLLECT),
    .kick_i   (data_val_i),
    .expire_o (expire)
  );

  // Next-state logic: data_i only enters the datapath on a qualified bit, so X on idle cycles is blocked.
  always_comb begin
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    data_d = data_q;
    val_d  = 1'b0;
    drop_d = 1'b0;
    if (data_val_i) begin
      if (cnt_q == LAST_BIT) begin
        cnt_d  = '0;
        sr_d   = '0;
        data_d = sr_shift;
        val_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sr_d  = sr_shift;
      end
    end else if (expire) begin
      cnt_d  = '0;
      sr_d   = '0;
      drop_d = 1'b1;
    end
  end

  // State and output registers; reset discards a partial word silently.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      data_q <= '0;
      val_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      data_q <= data_d;
      val_q  <= val_d;
      drop_q <= drop_d;
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_val_o = val_q;
  assign drop_o           = drop_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Self-checking bench: two deserializers (MSB-first and LSB-first) share one serial stream.
// A bit-queue model predicts words, valid pulses and drops; every cycle is compared.
// Directed scenarios pin the model with literal words, followed by a randomized run.
module tb_serial_word_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic        din;
  logic        dval;
  logic [15:0] m_data, l_data;
  logic        m_val, l_val, m_drop, l_drop;

  serial_word_deserializer #(.WIDTH(16), .LSB_FIRST(0), .GAP_TIMEOUT(8)) dut_msb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval),
    .deser_data_o(m_data), .deser_data_val_o(m_val), .drop_o(m_drop)
  );

  serial_word_deserializer #(.WIDTH(16), .LSB_FIRST(1), .GAP_TIMEOUT(8)) dut_lsb (
    .clk_i(clk), .srst_i(srst), .data_i(din), .data_val_i(dval),
    .deser_data_o(l_data), .deser_data_val_o(l_val), .drop_o(l_drop)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int drops_seen = 0;
  int pulse_cyc[$];

  // Reference model: pending bits of the partial word plus an idle-cycle count.
  logic        mq[$];
  int          idle_m = 0;
  logic [15:0] exp_msb = '0;
  logic [15:0] exp_lsb = '0;
  logic        exp_val = 1'b0;
  logic        exp_drop = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", nm, act, exp, cycle);
    end
  endtask

  task automatic model_step();
    exp_val  = 1'b0;
    exp_drop = 1'b0;
    if (srst) begin
      mq.delete();
      idle_m  = 0;
      exp_msb = '0;
      exp_lsb = '0;
    end else if (dval) begin
      mq.push_back(din);
      idle_m = 0;
      if (mq.size() == 16) begin
        for (int i = 0; i < 16; i++) begin
          exp_msb    = {exp_msb[14:0], mq[i]};
          exp_lsb[i] = mq[i];
        end
        exp_val = 1'b1;
        mq.delete();
      end
    end else if (mq.size() != 0) begin
      idle_m++;
      if (idle_m == 8) begin
        exp_drop = 1'b1;
        mq.delete();
        idle_m = 0;
      end
    end
  endtask

  task automatic compare();
    chk("msb_data", 32'(m_data), 32'(exp_msb));
    chk("lsb_data", 32'(l_data), 32'(exp_lsb));
    chk("msb_val",  32'(m_val),  32'(exp_val));
    chk("lsb_val",  32'(l_val),  32'(exp_val));
    chk("msb_drop", 32'(m_drop), 32'(exp_drop));
    chk("lsb_drop", 32'(l_drop), 32'(exp_drop));
    if (m_val) pulse_cyc.push_back(cycle);
    if (m_drop) drops_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    cycle++;
    model_step();
    #1;
    compare();
  endtask

  task automatic send_bit(input logic b);
    dval = 1'b1;
    din  = b;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dval = 1'b0;
      din  = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    int d0;
    logic [15:0] w;
    srst = 1'b1;
    dval = 1'b0;
    din  = 1'b0;
    tick();
    tick();
    chk("rst_data", 32'(m_data), 32'h0);
    chk("rst_val",  32'(m_val),  32'h0);
    srst = 1'b0;
    idle(2);

    // Words 1/2: same stream into both bit orders.
    send_word(16'hA5C3);
    chk("t1_model", 32'(exp_msb), 32'hA5C3);
    chk("t1_data",  32'(m_data),  32'hA5C3);
    chk("t1_val",   32'(m_val),   32'h1);
    chk("t2_data",  32'(l_data),  32'hC3A5);
    idle(1);
    chk("t1_val_end", 32'(m_val), 32'h0);
    chk("t1_hold",    32'(m_data), 32'hA5C3);

    // Gaps of 3 after the 4th and 11th bits must be tolerated.
    d0 = drops_seen;
    w = 16'h8001;
    for (int i = 0; i < 16; i++) begin
      send_bit(w[15-i]);
      if (i == 3 || i == 10) idle(3);
    end
    chk("t3_data",  32'(m_data), 32'h8001);
    chk("t3_nodrop", 32'(drops_seen), 32'(d0));

    // Partial word of 5 bits stalls for 8 cycles and is dropped.
    d0 = drops_seen;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    idle(7);
    chk("t4_predrop", 32'(m_drop), 32'h0);
    idle(1);
    chk("t4_drop",      32'(m_drop), 32'h1);
    chk("t4_data_kept", 32'(m_data), 32'h8001);
    idle(1);
    chk("t4_drop_end", 32'(m_drop), 32'h0);
    send_word(16'h00FF);
    chk("t4_data",  32'(m_data), 32'h00FF);
    chk("t4_ldata", 32'(l_data), 32'hFF00);
    chk("t4_ndrop", 32'(drops_seen), 32'(d0 + 1));

    // Back-to-back words: pulses exactly 16 cycles apart.
    pulse_cyc.delete();
    send_word(16'h1234);
    chk("t5_w0", 32'(m_data), 32'h1234);
    send_word(16'hFFFF);
    chk("t5_w1", 32'(m_data), 32'hFFFF);
    chk("t5_npulse", 32'(pulse_cyc.size()), 32'd2);
    chk("t5_gap", (pulse_cyc.size() == 2) ? 32'(pulse_cyc[1] - pulse_cyc[0]) : 32'hFFFF_FFFF, 32'd16);
    idle(1);

    // Reset mid-word (with a qualified bit present) discards it silently.
    for (int i = 0; i < 9; i++) send_bit(1'($urandom));
    d0 = drops_seen;
    srst = 1'b1;
    send_bit(1'b1);
    srst = 1'b0;
    chk("t6_rst_data", 32'(m_data), 32'h0);
    chk("t6_rst_val",  32'(m_val),  32'h0);
    chk("t6_rst_drop", 32'(m_drop), 32'h0);
    idle(12);
    chk("t6_nodrop", 32'(drops_seen), 32'(d0));
    send_word(16'h0F0F);
    chk("t6_data",  32'(m_data), 32'h0F0F);
    chk("t6_ldata", 32'(l_data), 32'hF0F0);

    // Randomized traffic with occasional long gaps and rare resets.
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 1) begin
        srst = 1'b1;
        dval = 1'(r & 1);
        din  = 1'($urandom);
        tick();
        srst = 1'b0;
      end else if (r < 7) begin
        idle(int'($urandom_range(1, 12)));
      end else begin
        dval = ($urandom_range(0, 99) < 75);
        din  = 1'($urandom);
        tick();
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
